mmu_ctx_sched: RTL and testbench
================================

# mmu_ctx_sched

Round-robin context-switch scheduler that sequences the MMU's segment registers. It holds a process table of up to 11 slots (base address + valid bit) loaded by the kernel and picks the next ready slot on kernel request. It programs the MMU selector and then the instruction-memory base, switches execution to user mode, and enforces a time quantum by raising a timer interrupt. It sits between the CPU control unit (kernel writes, `inta`) and the MMU's `we_sel`/`sel`/`we_addr`/`offset`/`userMode`/`kernelMode` inputs.

## Interface
- `NPROC`, 11, number of process slots (slot index 0..NPROC-1)
- `QW`, 16, quantum counter width
- `clk` input 1, system clock, all state on rising edge
- `rst_n` input 1, asynchronous active-low reset
- `cfg_we` input 1, write process-table entry this cycle
- `cfg_slot` input 4, slot index for `cfg_we`; values >= NPROC are ignored
- `cfg_base` input 32, base (lower bound) address written to the slot
- `cfg_valid` input 1, ready bit written to the slot
- `quantum` input QW, user-mode cycles per dispatch; 0 is treated as 1
- `start` input 1, kernel request to dispatch the next ready process
- `inta` input 1, CPU interrupt acknowledge / kernel entry
- `irq` output 1, timer interrupt request (quantum expired)
- `mmu_we_sel` output 1, selector write strobe to MMU
- `mmu_sel` output 32, selector value (zero-extended slot index)
- `mmu_we_addr` output 1, base write strobe to MMU
- `mmu_offset` output 32, base value for MMU
- `mmu_user_mode` output 1, one-cycle pulse: enter user mode
- `mmu_kernel_mode` output 1, one-cycle pulse: force kernel mode on expiry
- `cur_slot` output 4, slot most recently dispatched
- `busy` output 1, high in any state other than IDLE
- `none_ready` output 1, combinational: no slot has its valid bit set
- `start_err` output 1, one-cycle pulse: `start` taken in IDLE while `none_ready`

## Operation
- Table: NPROC entries of {valid, base[31:0]}. A `cfg_we` write takes effect at the next edge and is accepted in every state. An already-programmed MMU is not reprogrammed until the next dispatch.
- Next-slot selection scans (cur_slot+1) mod NPROC upward with wrap and takes the first valid entry. The current slot is considered last, so a single ready slot is re-dispatched.
- States:
  - IDLE: kernel mode. On `start`, if any slot is valid, latch next slot and its base, go to SEL. Otherwise pulse `start_err` and stay in IDLE.
  - SEL: `mmu_we_sel`=1, `mmu_sel`=latched slot, update `cur_slot`. Go to BASE.
  - BASE: `mmu_we_addr`=1, `mmu_offset`=latched base. Go to ENTER. The MMU indexes its base array by its registered selector, so BASE must follow SEL and never coincide with it.
  - ENTER: `mmu_user_mode`=1. Load counter with max(quantum,1). Go to RUN.
  - RUN: decrement counter each cycle. When counter==1 and no `inta`: pulse `mmu_kernel_mode`, go to IRQ. On `inta`: go to IDLE and discard the remaining quantum.
  - IRQ: `irq`=1 until `inta` is sampled high, then go to IDLE.
- `inta` in SEL/BASE/ENTER is ignored; the dispatch sequence completes atomically.
- `start` outside IDLE is ignored with no error.
- `cfg_we` to the latched slot during SEL/BASE does not alter the in-flight base, which was latched at `start`.
- Reset mid-operation: immediate return to IDLE, all strobes low, table cleared.

## Timing
- Reset values: state IDLE; all strobes, `irq`, `start_err` = 0; `mmu_sel`, `mmu_offset` = 0; `cur_slot` = NPROC-1, so the first dispatch scans from slot 0; all valid bits = 0; `busy` = 0; `none_ready` = 1.
- `start` sampled at edge t (IDLE) gives SEL in cycle t+1, BASE in t+2, ENTER in t+3, RUN in t+4 through t+3+Q, IRQ from t+4+Q.
- All strobes are registered, exactly one cycle wide, and mutually exclusive.
- `irq` is a level, held until `inta`. `inta` in IRQ gives IDLE in the next cycle; `start` is accepted on the cycle after that.

## Test plan
- Reset, write slots 2 (base 0x400) and 5 (base 0x900) valid, Q=3, pulse `start`:
  - `mmu_sel`=2 with `we_sel` at t+1; `offset`=0x400 with `we_addr` at t+2; `user_mode` at t+3; `irq` at t+7.
- Repeat the dispatch: slot 5 is selected, then slot 2 (wrap-around), with a 2,5,2 sequence across three `inta`/`start` rounds.
- `start` with all slots invalid -> `start_err` pulse, `busy` stays 0, no MMU strobes.
- `inta` during RUN with Q=10 at the 4th RUN cycle -> IDLE next cycle, no `irq`, no `mmu_kernel_mode`.
- Q=0 -> RUN lasts exactly 1 cycle, then `irq`.
- `rst_n` low during BASE -> all outputs return to reset values asynchronously; after release, `start` with slot 0 valid selects slot 0.

Source files
------------

// File: rtl/mmu_ctx_sched_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mmu_ctx_sched_if                                                          |
// | Kernel-side configuration/control and MMU programming bundle.             |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
interface mmu_ctx_sched_if #(
    parameter int QW = 16
);
    logic          cfg_we;
    logic [3:0]    cfg_slot;
    logic [31:0]   cfg_base;
    logic          cfg_valid;
    logic [QW-1:0] quantum;
    logic          start;
    logic          inta;
    logic          irq;
    logic          mmu_we_sel;
    logic [31:0]   mmu_sel;
    logic          mmu_we_addr;
    logic [31:0]   mmu_offset;
    logic          mmu_user_mode;
    logic          mmu_kernel_mode;
    logic [3:0]    cur_slot;
    logic          busy;
    logic          none_ready;
    logic          start_err;

    modport slave (
        input  cfg_we, cfg_slot, cfg_base, cfg_valid, quantum, start, inta,
        output irq, mmu_we_sel, mmu_sel, mmu_we_addr, mmu_offset,
               mmu_user_mode, mmu_kernel_mode, cur_slot, busy, none_ready,
               start_err
    );

    modport master (
        output cfg_we, cfg_slot, cfg_base, cfg_valid, quantum, start, inta,
        input  irq, mmu_we_sel, mmu_sel, mmu_we_addr, mmu_offset,
               mmu_user_mode, mmu_kernel_mode, cur_slot, busy, none_ready,
               start_err
    );
endinterface
`default_nettype wire

// File: rtl/mmu_ctx_sched.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mmu_ctx_sched                                                             |
// | Round-robin context scheduler: programs MMU selector/base, runs quantum.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module mmu_ctx_sched #(
    parameter int NPROC = 11,
    parameter int QW    = 16
) (
    input  wire               clk,
    input  wire               rst_n,
    mmu_ctx_sched_if.slave    bus
);
    localparam logic [3:0] C_LAST_SLOT = 4'(NPROC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEL   = 3'd1,
        BASE  = 3'd2,
        ENTER = 3'd3,
        RUN   = 3'd4,
        IRQ   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   base_tbl_q [NPROC];
    logic [NPROC-1:0] valid_q;

    logic          we_sel_q, we_sel_d;
    logic          we_addr_q, we_addr_d;
    logic          user_q, user_d;
    logic          kern_q, kern_d;
    logic          irq_q, irq_d;
    logic          err_q, err_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   offset_q, offset_d;
    logic [3:0]    cur_q, cur_d;
    logic [31:0]   base_q, base_d;
    logic [QW-1:0] cnt_q, cnt_d;

    logic [4:0]    scan_sum;
    logic [3:0]    nxt_slot;
    logic          none_ready;

    assign none_ready = ~|valid_q;

    // Descending scan so the nearest valid slot after cur_q wins; cur_q itself is tried last.
    always_comb begin
        nxt_slot = cur_q;
        scan_sum = '0;
        for (int i = NPROC; i >= 1; i--) begin
            scan_sum = {1'b0, cur_q} + 5'(i);
            if (scan_sum >= 5'(NPROC)) begin
                scan_sum = scan_sum - 5'(NPROC);
            end
            if (valid_q[scan_sum[3:0]]) begin
                nxt_slot = scan_sum[3:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        we_sel_d  = 1'b0;
        we_addr_d = 1'b0;
        user_d    = 1'b0;
        kern_d    = 1'b0;
        err_d     = 1'b0;
        sel_d     = sel_q;
        offset_d  = offset_q;
        cur_d     = cur_q;
        base_d    = base_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (none_ready) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = SEL;
                        we_sel_d = 1'b1;
                        sel_d    = nxt_slot;
                        cur_d    = nxt_slot;
                        base_d   = base_tbl_q[nxt_slot];
                    end
                end
            end
            SEL: begin
                state_d   = BASE;
                we_addr_d = 1'b1;
                offset_d  = base_q;
            end
            BASE: begin
                state_d = ENTER;
                user_d  = 1'b1;
            end
            ENTER: begin
                state_d = RUN;
                cnt_d   = (bus.quantum == '0) ? QW'(1) : bus.quantum;
            end
            RUN: begin
                if (bus.inta) begin
                    state_d = IDLE;
                end else if (cnt_q == QW'(1)) begin
                    state_d = IRQ;
                    kern_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - QW'(1);
                end
            end
            IRQ: begin
                if (bus.inta) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        irq_d = (state_d == IRQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            we_sel_q  <= 1'b0;
            we_addr_q <= 1'b0;
            user_q    <= 1'b0;
            kern_q    <= 1'b0;
            irq_q     <= 1'b0;
            err_q     <= 1'b0;
            sel_q     <= '0;
            offset_q  <= '0;
            cur_q     <= C_LAST_SLOT;
            base_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            we_sel_q  <= we_sel_d;
            we_addr_q <= we_addr_d;
            user_q    <= user_d;
            kern_q    <= kern_d;
            irq_q     <= irq_d;
            err_q     <= err_d;
            sel_q     <= sel_d;
            offset_q  <= offset_d;
            cur_q     <= cur_d;
            base_q    <= base_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < NPROC; i++) begin
                base_tbl_q[i] <= '0;
            end
        end else if (bus.cfg_we && (bus.cfg_slot < 4'(NPROC))) begin
            valid_q[bus.cfg_slot]    <= bus.cfg_valid;
            base_tbl_q[bus.cfg_slot] <= bus.cfg_base;
        end
    end

    assign bus.irq             = irq_q;
    assign bus.mmu_we_sel      = we_sel_q;
    assign bus.mmu_sel         = {28'd0, sel_q};
    assign bus.mmu_we_addr     = we_addr_q;
    assign bus.mmu_offset      = offset_q;
    assign bus.mmu_user_mode   = user_q;
    assign bus.mmu_kernel_mode = kern_q;
    assign bus.cur_slot        = cur_q;
    assign bus.busy            = (state_q != IDLE);
    assign bus.none_ready      = none_ready;
    assign bus.start_err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mmu_ctx_sched.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_mmu_ctx_sched                                                          |
// | Directed self-checking bench for the context-switch scheduler.            |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_mmu_ctx_sched;
    localparam int NPROC = 11;
    localparam int QW    = 16;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    mmu_ctx_sched_if #(.QW(QW)) bus ();

    mmu_ctx_sched #(.NPROC(NPROC), .QW(QW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [3:0] slot, input logic [31:0] base, input logic vld);
        bus.cfg_we    = 1'b1;
        bus.cfg_slot  = slot;
        bus.cfg_base  = base;
        bus.cfg_valid = vld;
        tick();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_busy"},   {31'd0, bus.busy}, 32'd0);
        chk({pfx, "_nready"}, {31'd0, bus.none_ready}, 32'd1);
        chk({pfx, "_irq"},    {31'd0, bus.irq}, 32'd0);
        chk({pfx, "_strobes"}, {28'd0, bus.mmu_we_sel, bus.mmu_we_addr,
                                bus.mmu_user_mode, bus.mmu_kernel_mode}, 32'd0);
        chk({pfx, "_sel"},    bus.mmu_sel, 32'd0);
        chk({pfx, "_offset"}, bus.mmu_offset, 32'd0);
        chk({pfx, "_cur"},    {28'd0, bus.cur_slot}, 32'd10);
        chk({pfx, "_err"},    {31'd0, bus.start_err}, 32'd0);
    endtask

    // Full dispatch from IDLE through quantum expiry and acknowledge.
    task automatic dispatch(input logic [3:0] slot, input logic [31:0] base, input int q);
        int nrun;
        nrun = (q == 0) ? 1 : q;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("sel_we",   {31'd0, bus.mmu_we_sel}, 32'd1);
        chk("sel_val",  bus.mmu_sel, {28'd0, slot});
        chk("sel_busy", {31'd0, bus.busy}, 32'd1);
        chk("sel_addrwe", {31'd0, bus.mmu_we_addr}, 32'd0);
        tick();
        chk("base_we",  {31'd0, bus.mmu_we_addr}, 32'd1);
        chk("base_val", bus.mmu_offset, base);
        chk("base_selwe", {31'd0, bus.mmu_we_sel}, 32'd0);
        chk("cur_slot", {28'd0, bus.cur_slot}, {28'd0, slot});
        tick();
        chk("user",     {31'd0, bus.mmu_user_mode}, 32'd1);
        chk("user_addrwe", {31'd0, bus.mmu_we_addr}, 32'd0);
        for (int i = 0; i < nrun; i++) begin
            tick();
            chk("run_irq",  {31'd0, bus.irq}, 32'd0);
            chk("run_kmode", {31'd0, bus.mmu_kernel_mode}, 32'd0);
        end
        tick();
        chk("irq",   {31'd0, bus.irq}, 32'd1);
        chk("kmode", {31'd0, bus.mmu_kernel_mode}, 32'd1);
        tick();
        chk("irq_hold",  {31'd0, bus.irq}, 32'd1);
        chk("kmode_end", {31'd0, bus.mmu_kernel_mode}, 32'd0);
        bus.inta = 1'b1;
        tick();
        bus.inta = 1'b0;
        chk("ack_irq",  {31'd0, bus.irq}, 32'd0);
        chk("ack_busy", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n         = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_slot  = 4'd0;
        bus.cfg_base  = 32'd0;
        bus.cfg_valid = 1'b0;
        bus.quantum   = 16'd3;
        bus.start     = 1'b0;
        bus.inta      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_reset_outputs("rst");

        // Out-of-range slot write must not mark anything ready
        cfg_wr(4'd12, 32'hDEAD_0000, 1'b1);
        chk("oob_nready", {31'd0, bus.none_ready}, 32'd1);

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("err_pulse", {31'd0, bus.start_err}, 32'd1);
        chk("err_busy",  {31'd0, bus.busy}, 32'd0);
        chk("err_selwe", {31'd0, bus.mmu_we_sel}, 32'd0);
        tick();
        chk("err_end",   {31'd0, bus.start_err}, 32'd0);
        chk("err_addrwe", {31'd0, bus.mmu_we_addr}, 32'd0);

        cfg_wr(4'd2, 32'h0000_0400, 1'b1);
        cfg_wr(4'd5, 32'h0000_0900, 1'b1);
        chk("cfg_nready", {31'd0, bus.none_ready}, 32'd0);

        bus.quantum = 16'd3;
        dispatch(4'd2, 32'h400, 3);
        dispatch(4'd5, 32'h900, 3);
        dispatch(4'd2, 32'h400, 3);

        // Early kernel entry at the 4th RUN cycle with Q=10
        bus.quantum = 16'd10;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("ea_sel", bus.mmu_sel, 32'd5);
        tick();
        tick();
        tick();
        tick();
        tick();
        tick();
        chk("ea_busy_run4", {31'd0, bus.busy}, 32'd1);
        bus.inta = 1'b1;
        tick();
        bus.inta = 1'b0;
        chk("ea_idle", {31'd0, bus.busy}, 32'd0);
        chk("ea_irq",  {31'd0, bus.irq}, 32'd0);
        chk("ea_kmode", {31'd0, bus.mmu_kernel_mode}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("ea_quiet", {30'd0, bus.irq, bus.mmu_kernel_mode}, 32'd0);
        end

        bus.quantum = 16'd0;
        dispatch(4'd2, 32'h400, 0);

        // Asynchronous reset in the middle of BASE
        bus.quantum = 16'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("mr_sel", bus.mmu_sel, 32'd5);
        tick();
        chk("mr_base_we", {31'd0, bus.mmu_we_addr}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mr");
        tick();
        rst_n = 1'b1;
        tick();
        chk_reset_outputs("post");
        cfg_wr(4'd0, 32'h0000_0123, 1'b1);
        bus.quantum = 16'd2;
        dispatch(4'd0, 32'h123, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
